// File: rtl/rsr_deserializer_if.sv
// Serial capture / word handshake bundle for rsr_deserializer.
// master: deserializer side, slave: upstream source plus word consumer.
interface rsr_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_en;
  logic             frame;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;
  logic             frame_err;
  logic             parity_err;
  logic             err_clr;

  modport master (
    input  sin,
    input  sin_en,
    input  frame,
    input  dout_ready,
    input  err_clr,
    output dout,
    output dout_valid,
    output busy,
    output overrun,
    output frame_err,
    output parity_err
  );

  modport slave (
    output sin,
    output sin_en,
    output frame,
    output dout_ready,
    output err_clr,
    input  dout,
    input  dout_valid,
    input  busy,
    input  overrun,
    input  frame_err,
    input  parity_err
  );
endinterface

// File: rtl/rsr_deserializer.sv
// LSB-first serial-to-parallel capture with a 2-entry word queue.
// Optional trailing even-parity bit: define RSR_DES_PARITY_EN.
module rsr_deserializer #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  rsr_deserializer_if.master io
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef RSR_DES_PARITY_EN
    S_PAR,
`endif
    S_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_n;
  logic [CW-1:0]    r_bitcnt;
  logic [CW-1:0]    w_bitcnt_n;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_push;
  logic             w_ferr_set;

  logic [WIDTH-1:0] r_q0;
  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] w_q0_n;
  logic [WIDTH-1:0] w_q1_n;
  logic [1:0]       r_qcnt;
  logic [1:0]       w_qcnt_n;
  logic             w_pop;
  logic             w_ovr_set;

  logic             r_valid;
  logic             r_busy;
  logic             r_ovr;
  logic             r_ferr;

`ifdef RSR_DES_PARITY_EN
  logic             w_perr_set;
  logic             r_perr;
`else
  logic             w_unused;
`endif

  assign w_shift = {io.sin, r_sreg[WIDTH-1:1]};
  assign w_pop   = r_valid & io.dout_ready;

  // Bit collection: next state, shift register, bit counter, word push.
  always_comb begin
    w_state_n  = r_state;
    w_sreg_n   = r_sreg;
    w_bitcnt_n = r_bitcnt;
    w_push     = 1'b0;
    w_word     = w_shift;
    w_ferr_set = 1'b0;
`ifdef RSR_DES_PARITY_EN
    w_perr_set = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (io.sin_en && io.frame) begin
          w_state_n  = S_SHIFT;
          w_sreg_n   = w_shift;
          w_bitcnt_n = CW'(1);
        end
      end
      S_SHIFT: begin
        if (io.sin_en && io.frame) begin
          w_ferr_set = 1'b1;
          w_sreg_n   = w_shift;
          w_bitcnt_n = CW'(1);
        end else if (io.sin_en) begin
          w_sreg_n   = w_shift;
          w_bitcnt_n = r_bitcnt + CW'(1);
          if (r_bitcnt == CW'(WIDTH - 1)) begin
`ifdef RSR_DES_PARITY_EN
            w_state_n  = S_PAR;
`else
            w_push     = 1'b1;
            w_state_n  = S_IDLE;
            w_bitcnt_n = '0;
`endif
          end
        end
      end
`ifdef RSR_DES_PARITY_EN
      S_PAR: begin
        w_word = r_sreg;
        if (io.sin_en && io.frame) begin
          w_ferr_set = 1'b1;
          w_state_n  = S_SHIFT;
          w_sreg_n   = w_shift;
          w_bitcnt_n = CW'(1);
        end else if (io.sin_en) begin
          // Even parity: data ones plus parity bit is even.
          if (io.sin == ^r_sreg) begin
            w_push = 1'b1;
          end else begin
            w_perr_set = 1'b1;
          end
          w_state_n  = S_IDLE;
          w_bitcnt_n = '0;
        end
      end
`endif
      default: begin
        w_state_n  = S_IDLE;
        w_bitcnt_n = '0;
      end
    endcase
  end

  // Two-entry FIFO: q0 is the head, pop and push may share a cycle.
  always_comb begin
    w_q0_n    = r_q0;
    w_q1_n    = r_q1;
    w_qcnt_n  = r_qcnt;
    w_ovr_set = 1'b0;
    unique case (r_qcnt)
      2'd0: begin
        if (w_push) begin
          w_q0_n   = w_word;
          w_qcnt_n = 2'd1;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          w_q0_n   = w_word;
        end else if (w_push) begin
          w_q1_n   = w_word;
          w_qcnt_n = 2'd2;
        end else if (w_pop) begin
          w_qcnt_n = 2'd0;
        end
      end
      2'd2: begin
        if (w_push && w_pop) begin
          w_q0_n   = r_q1;
          w_q1_n   = w_word;
        end else if (w_pop) begin
          w_q0_n   = r_q1;
          w_qcnt_n = 2'd1;
        end else if (w_push) begin
          w_ovr_set = 1'b1;
        end
      end
      default: begin
        w_qcnt_n = 2'd0;
      end
    endcase
  end

  // Collector state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_sreg   <= '0;
      r_bitcnt <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_sreg   <= w_sreg_n;
      r_bitcnt <= w_bitcnt_n;
      r_busy   <= (w_state_n != S_IDLE);
    end
  end

  // Queue storage and registered valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q0    <= '0;
      r_q1    <= '0;
      r_qcnt  <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_q0    <= w_q0_n;
      r_q1    <= w_q1_n;
      r_qcnt  <= w_qcnt_n;
      r_valid <= (w_qcnt_n != 2'd0);
    end
  end

  // Sticky flags: a set in the clearing cycle wins over err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set | (r_ovr & ~io.err_clr);
      r_ferr <= w_ferr_set | (r_ferr & ~io.err_clr);
    end
  end

`ifdef RSR_DES_PARITY_EN
  // Sticky parity flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_perr_set | (r_perr & ~io.err_clr);
    end
  end

  assign io.parity_err = r_perr;
`else
  assign w_unused      = r_sreg[0];
  assign io.parity_err = 1'b0;
`endif

  assign io.dout       = r_q0;
  assign io.dout_valid = r_valid;
  assign io.busy       = r_busy;
  assign io.overrun    = r_ovr;
  assign io.frame_err  = r_ferr;

endmodule

// File: tb/tb_rsr_deserializer.sv
// Bench for rsr_deserializer: directed scenarios then random traffic,
// all checked against a bit-list / word-queue reference model.
module tb_rsr_deserializer;

  localparam int W = 4;
`ifdef RSR_DES_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rsr_deserializer_if #(.WIDTH(W)) bus ();

  rsr_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int errs   = 0;
  int checks = 0;

  bit m_bits[$];
  int m_q[$];
  bit m_in;
  bit m_ovr;
  bit m_fe;
  bit m_pe;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pack_bits();
    int w = 0;
    for (int i = 0; i < m_bits.size(); i++)
      w |= int'(m_bits[i]) << i;
    return w;
  endfunction

  // Reference: words are lists of received bits; queue is a plain list.
  task automatic model(input bit s, input bit en, input bit fr,
                       input bit rdy, input bit clr);
    bit pop  = (m_q.size() > 0) && rdy;
    bit push = 1'b0;
    bit fe   = 1'b0;
    bit pe   = 1'b0;
    bit ov   = 1'b0;
    int word = 0;
    if (en) begin
      if (fr) begin
        fe = m_in;
        m_bits.delete();
        m_bits.push_back(s);
        m_in = 1'b1;
      end else if (m_in) begin
        if (m_bits.size() == W) begin
          word = pack_bits();
          if (s == ^word) push = 1'b1;
          else pe = 1'b1;
          m_in = 1'b0;
          m_bits.delete();
        end else begin
          m_bits.push_back(s);
          if (m_bits.size() == W && !PAR) begin
            word = pack_bits();
            push = 1'b1;
            m_in = 1'b0;
            m_bits.delete();
          end
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() == 2) ov = 1'b1;
      else m_q.push_back(word);
    end
    m_ovr = ov | (m_ovr & !clr);
    m_fe  = fe | (m_fe & !clr);
    m_pe  = pe | (m_pe & !clr);
  endtask

  task automatic compare_all();
    chk("dout_valid", 32'(bus.dout_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0)
      chk("dout", 32'(bus.dout), 32'(m_q[0]));
    chk("busy", 32'(bus.busy), 32'(m_in));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    chk("frame_err", 32'(bus.frame_err), 32'(m_fe));
    chk("parity_err", 32'(bus.parity_err), 32'(m_pe));
  endtask

  task automatic step(input bit s, input bit en, input bit fr,
                      input bit rdy, input bit clr);
    @(negedge clk);
    bus.sin        = s;
    bus.sin_en     = en;
    bus.frame      = fr;
    bus.dout_ready = rdy;
    bus.err_clr    = clr;
    @(posedge clk);
    model(s, en, fr, rdy, clr);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Frame + W bits (+ correct parity); rmask bit i = ready on bit i.
  task automatic send_word(input int w, input int rmask);
    for (int i = 0; i < W; i++)
      step(bit'((w >> i) & 1), 1'b1, i == 0, bit'((rmask >> i) & 1), 1'b0);
    if (PAR)
      step(^(w & ((1 << W) - 1)), 1'b1, 1'b0, bit'((rmask >> W) & 1), 1'b0);
  endtask

  task automatic reset_checks();
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_valid", 32'(bus.dout_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_parity_err", 32'(bus.parity_err), 32'h0);
  endtask

  // Asynchronous reset between clock edges, checked before any edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    bus.sin_en     = 1'b0;
    bus.frame      = 1'b0;
    bus.dout_ready = 1'b0;
    bus.err_clr    = 1'b0;
    rst            = 1'b0;
    #1;
    reset_checks();
    m_bits.delete();
    m_q.delete();
    m_in  = 1'b0;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    m_pe  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    bus.sin        = 1'b0;
    bus.sin_en     = 1'b0;
    bus.frame      = 1'b0;
    bus.dout_ready = 1'b0;
    bus.err_clr    = 1'b0;
    m_in  = 1'b0;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    m_pe  = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks();
    rst = 1'b1;

    idle(2, 1'b1);
    send_word(4'hD, -1);
    idle(3, 1'b1);

    send_word(4'h3, 0);
    send_word(4'h5, 0);
    send_word(4'h9, 0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);

    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(4'hA, -1);
    idle(2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    send_word(4'h1, 0);
    send_word(4'h2, 0);
    send_word(4'h4, 1 << (W - 1 + int'(PAR)));
    idle(4, 1'b1);

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_word(4'h6, 0);
    do_reset();
    send_word(4'hB, 0);
    idle(2, 1'b1);

    if (PAR) begin
      send_word(4'h7, -1);
      idle(2, 1'b1);
      for (int i = 0; i < W; i++)
        step(bit'((7 >> i) & 1), 1'b1, i == 0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
    end

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step(bit'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 19) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rsr_deserializer.md
# rsr_deserializer

Serial-to-parallel capture stage that sits directly downstream of the 4-bit right shift register. It samples the register's LSB-first serial output one bit per strobe and assembles WIDTH-bit words. Completed words are buffered in a 2-entry output queue and presented on a valid/ready handshake, with sticky error flags for overrun and framing faults.

## Interface
- WIDTH, 4, data bits per word (2..16)
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- sin  in  1  serial data bit (upstream shift register q[0])
- sin_en  in  1  bit strobe; sin sampled on rising clk when high
- frame  in  1  start-of-word marker, qualified by sin_en; the bit sampled with it is bit 0
- dout  out  WIDTH  head-of-queue word, bit i = i-th bit received
- dout_valid  out  1  queue non-empty
- dout_ready  in  1  consumer accepts dout this cycle
- busy  out  1  word collection in progress (state SHIFT)
- overrun  out  1  sticky: completed word dropped, queue full
- frame_err  out  1  sticky: frame seen mid-word, partial word discarded
- parity_err  out  1  sticky: parity mismatch (see Configuration)
- err_clr  in  1  synchronous clear of all sticky flags

## Operation
- States: IDLE, SHIFT (plus PAR when parity compiled in).
- IDLE: sin_en & frame -> SHIFT, sreg <= {sin, sreg[WIDTH-1:1]}, bitcnt <= 1. sin_en without frame ignored.
- SHIFT: each sin_en shifts sin into sreg MSB end (right shift), bitcnt+1. When the WIDTH-th bit is sampled, word = new sreg value; push to queue; -> IDLE (or PAR).
- SHIFT with sin_en & frame: partial word discarded, frame_err <= 1, the bit restarts a new word (bitcnt <= 1), stays SHIFT.
- Queue: 2 entries, FIFO order. Push when full and no pop same cycle: word dropped, overrun <= 1. Push and pop same cycle when full: both succeed, count stays 2.
- Pop on dout_valid & dout_ready; dout_ready with empty queue ignored.
- dout holds stable while dout_valid & !dout_ready.
- err_clr has priority below a same-cycle set: a flag set event in the clearing cycle leaves the flag 1.
- Reset (any time, including mid-word): state IDLE, bitcnt 0, queue empty, partial word lost.

## Timing
- Reset values: dout 0, dout_valid 0, busy 0, overrun 0, frame_err 0, parity_err 0.
- Latency: last data bit sampled on edge N -> dout_valid 1 and dout valid after edge N (visible cycle N+1); no combinational path sin -> dout.
- Throughput: one bit per cycle sustained; back-to-back words need frame on the first bit of each.
- busy high from edge after frame bit until edge completing the word.
- dout_valid deasserts on the edge popping the last entry.
- All outputs registered.

## Configuration
- RSR_DES_PARITY_EN defined: after WIDTH data bits, state PAR takes one more sin_en bit as even parity over data. Match -> push; mismatch -> drop word, parity_err <= 1. frame during PAR -> frame_err, restart as in SHIFT. Latency counted from parity bit edge.
- Undefined: no PAR state, word pushed on WIDTH-th bit, parity_err tied 0.

## Test plan
- Reset, then frame+bits 1,0,1,1 (LSB first) on 4 consecutive cycles, dout_ready=1 -> dout=4'b1101 valid one cycle, busy low after.
- Three words 4'h3, 4'h5, 4'h9 back-to-back with dout_ready=0 -> queue holds 3,5; 9 dropped, overrun=1; then ready=1 pops 3 then 5; err_clr -> overrun=0.
- Frame after 2 bits of a word, then 4 bits of 4'hA -> frame_err=1, only 4'hA delivered.
- Queue full, push completes in same cycle as pop -> no overrun, next two pops in order.
- rst low mid-word (after 2 bits) and again with queue holding 1 entry -> all outputs return to reset values asynchronously; next full frame captured correctly.
- With RSR_DES_PARITY_EN: 4'h7 + parity 1 -> delivered; 4'h7 + parity 0 -> not delivered, parity_err=1.
